ser_sched: RTL

SER_SCHED -- requirements
Module: ser_sched

---
 rtl/ser_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ser_sched.sv
// ser_sched: round-robin scheduler that picks one of four requesters and
// shifts its captured nibble out LSB first as a framed serial stream.
// Optional feature macro: SER_SCHED_PARITY_EN appends an even-parity bit
// (XOR of the nibble) to every frame, which makes the frame 5 cycles long.
//
// state | meaning
// IDLE  | no frame in flight; req_i is sampled on every edge
// SHIFT | frame bits on serial_o; req_i is sampled on the final bit
module ser_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_i,
  input  logic [15:0] data_i,
  output logic [3:0]  gnt_o,
  output logic        serial_o,
  output logic        valid_o,
  output logic        last_o,
  output logic [1:0]  id_o,
  output logic        busy_o
);

`ifdef SER_SCHED_PARITY_EN
  localparam int FW = 5;
`else
  localparam int FW = 4;
`endif
  localparam logic [2:0] LAST_CNT = 3'(FW - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [FW-1:0] shreg, shreg_nxt;
  logic [1:0]    id, id_nxt;
  logic [3:0]    gnt, gnt_nxt;

  logic          decide;
  logic          win_found;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic [FW-1:0] load;

  // Round-robin search: first set request at or above ptr, wrapping mod 4.
  // Scanning offsets downward lets the smallest offset win.
  always_comb begin
    win_found = 1'b0;
    win       = ptr;
    idx       = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req_i[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  assign nib = data_i[{win, 2'b00} +: 4];

`ifdef SER_SCHED_PARITY_EN
  assign load = {^nib, nib};
`else
  assign load = nib;
`endif

  // Next-state: shift while in a frame, and re-arbitrate at decision points.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    shreg_nxt = shreg;
    id_nxt    = id;
    gnt_nxt   = 4'b0000;
    decide    = (state == IDLE) || ((state == SHIFT) && (cnt == LAST_CNT));

    if (state == SHIFT) begin
      cnt_nxt   = cnt + 3'd1;
      shreg_nxt = shreg >> 1;
    end

    if (decide) begin
      if (win_found) begin
        state_nxt = SHIFT;
        cnt_nxt   = 3'd0;
        ptr_nxt   = win + 2'd1;
        shreg_nxt = load;
        id_nxt    = win;
        gnt_nxt   = 4'b0001 << win;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
        shreg_nxt = '0;
        id_nxt    = 2'd0;
      end
    end
  end

  // State register with synchronous active-low reset; a reset drops any
  // frame in flight and its nibble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      ptr   <= 2'd0;
      shreg <= '0;
      id    <= 2'd0;
      gnt   <= 4'b0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      shreg <= shreg_nxt;
      id    <= id_nxt;
      gnt   <= gnt_nxt;
    end
  end

  assign busy_o   = (state == SHIFT);
  assign valid_o  = busy_o;
  assign serial_o = busy_o & shreg[0];
  assign last_o   = busy_o && (cnt == LAST_CNT);
  assign id_o     = busy_o ? id : 2'd0;
  assign gnt_o    = gnt;

endmodule
